// File: rtl/z88_mem_pkg.sv
// Shared definitions for Z88 memory-bus masters: arbiter states, chip-select
// region codes and the physical address width.
package z88_mem_pkg;

  localparam int MA_W = 22;

  // Region codes found in ma[21:19].
  localparam logic [2:0] ROM_SEL = 3'b000;
  localparam logic [2:0] RAM_SEL = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    SCR_ACC = 2'd2,
    TURN    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_cs_decode.sv
// Combinational chip-select decode from the memory address. Both enables stay
// high unless an access is active and the top three address bits select them.
module mem_cs_decode
  import z88_mem_pkg::*;
(
  input  logic [MA_W-1:0] ma,
  input  logic            active,
  output logic            ipce_n,
  output logic            irce_n
);

  logic [2:0] region;

  assign region = ma[MA_W-1 -: 3];
  assign ipce_n = !(active && (region == ROM_SEL));
  assign irce_n = !(active && (region == RAM_SEL));

endmodule

// File: rtl/mem_arbiter.sv
// Request/grant scheduler sharing the Z88 memory bus between the CPU and the
// screen fetcher. Define MEM_ARBITER_STARVE_GUARD_EN to force screen slots.
module mem_arbiter
  import z88_mem_pkg::*;
#(
  parameter int ACC_CYC    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic            mck,
  input  logic            rin_n,
  input  logic            lcdon,
  input  logic            cpu_mrq_n,
  input  logic            cpu_rd_n,
  input  logic            cpu_wr_n,
  input  logic [MA_W-1:0] cpu_a,
  input  logic [7:0]      cpu_do,
  output logic            cpu_wait_n,
  output logic            cpu_ack,
  input  logic            scr_req,
  input  logic [MA_W-1:0] scr_a,
  output logic            scr_ack,
  output logic [7:0]      rdata,
  input  logic [7:0]      cdi,
  output logic [MA_W-1:0] ma,
  output logic [7:0]      mdo,
  output logic            moe_n,
  output logic            mwe_n,
  output logic            ipce_n,
  output logic            irce_n
);

  if (ACC_CYC < 1 || ACC_CYC > 7) begin : g_bad_acc_cyc
    $error("mem_arbiter: ACC_CYC must be 1..7");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be 1..15");
  end

  localparam logic [2:0] LAST_CYC = 3'(ACC_CYC - 1);

  arb_state_e state, state_nxt;
  logic [2:0] cnt;
  logic       wr;
  logic       cpu_req, scr_v, scr_force;
  logic       grant_cpu, grant_scr;
  logic       access, last;

  assign cpu_req = !cpu_mrq_n && (!cpu_rd_n || !cpu_wr_n);
  assign scr_v   = scr_req && lcdon;
  assign access  = (state == CPU_ACC) || (state == SCR_ACC);
  assign last    = access && (cnt == LAST_CYC);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      starve_cnt <= '0;
    end else if (grant_scr) begin
      starve_cnt <= '0;
    end else if (scr_v && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign scr_force = (starve_cnt == STARVE_LIM);
`else
  assign scr_force = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_scr = 1'b0;
    case (state)
      IDLE: begin
        if (scr_v && (scr_force || !cpu_req)) begin
          grant_scr = 1'b1;
          state_nxt = SCR_ACC;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_ACC;
        end
      end
      CPU_ACC, SCR_ACC: if (last) state_nxt = TURN;
      TURN:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr      <= 1'b0;
      ma      <= '0;
      mdo     <= '0;
      rdata   <= '0;
      cpu_ack <= 1'b0;
      scr_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_ack <= 1'b0;
      scr_ack <= 1'b0;
      if (grant_cpu) begin
        ma  <= cpu_a;
        mdo <= cpu_do;
        wr  <= !cpu_wr_n;
        cnt <= '0;
      end
      if (grant_scr) begin
        ma  <= scr_a;
        wr  <= 1'b0;
        cnt <= '0;
      end
      if (access) cnt <= cnt + 3'd1;
      // Acks land in the TURN cycle, together with the freshly captured rdata.
      if (last) begin
        if (!wr) rdata <= cdi;
        cpu_ack <= (state == CPU_ACC);
        scr_ack <= (state == SCR_ACC);
      end
    end
  end

  assign cpu_wait_n = !(cpu_req && !cpu_ack);
  assign moe_n      = !(access && !wr);
  // Writes into the ROM region are dropped, but the slot still runs and acks.
  assign mwe_n      = !(access && wr && (ma[MA_W-1 -: 3] != ROM_SEL));

  mem_cs_decode u_cs (
    .ma     (ma),
    .active (access),
    .ipce_n (ipce_n),
    .irce_n (irce_n)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus random bench for mem_arbiter: a small byte memory answers on
// cdi, and a transaction-level model predicts latency, bus strobes and rdata.
module tb_mem_arbiter;

  localparam int ACC_CYC    = 2;
  localparam int STARVE_MAX = 8;

  // Valid/ready contract: a requester holds its request until the matching
  // one-cycle ack; rdata is valid in that ack cycle.
  logic        mck = 1'b0;
  logic        rin_n = 1'b0;
  logic        lcdon = 1'b1;
  logic        cpu_mrq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic [21:0] cpu_a = '0;
  logic [7:0]  cpu_do = '0;
  logic        cpu_wait_n, cpu_ack;
  logic        scr_req = 1'b0;
  logic [21:0] scr_a = '0;
  logic        scr_ack;
  logic [7:0]  rdata, cdi, mdo;
  logic [21:0] ma;
  logic        moe_n, mwe_n, ipce_n, irce_n;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  seed_mem[64];
  logic [7:0]  ref_mem[64];
  logic [7:0]  dev_mem[64];
  bit          mem_load = 1'b1;
  logic [7:0]  last_rd = '0;

  mem_arbiter #(.ACC_CYC(ACC_CYC), .STARVE_MAX(STARVE_MAX)) dut (
    .mck(mck), .rin_n(rin_n), .lcdon(lcdon),
    .cpu_mrq_n(cpu_mrq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_wait_n(cpu_wait_n), .cpu_ack(cpu_ack),
    .scr_req(scr_req), .scr_a(scr_a), .scr_ack(scr_ack), .rdata(rdata),
    .cdi(cdi), .ma(ma), .mdo(mdo), .moe_n(moe_n), .mwe_n(mwe_n),
    .ipce_n(ipce_n), .irce_n(irce_n)
  );

  // clock / reset
  always #5 mck = ~mck;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Memory device: write-enable alone commits, read data follows ma.
  assign cdi = dev_mem[ma[5:0]];
  always @(posedge mck) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= seed_mem[i];
    end else if (!mwe_n) begin
      dev_mem[ma[5:0]] <= mdo;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected {moe_n, mwe_n, ipce_n, irce_n} while an access is on the bus.
  function automatic logic [3:0] exp_bus(input bit wr, input logic [21:0] a);
    logic [2:0] region;
    region = a[21:19];
    return {wr, !(wr && region != 3'b000), region != 3'b000, region != 3'b001};
  endfunction

  // driver tasks
  task automatic drive_cpu(input bit wr, input logic [21:0] a, input logic [7:0] d);
    cpu_a = a; cpu_do = d; cpu_mrq_n = 1'b0; cpu_rd_n = wr; cpu_wr_n = !wr;
  endtask

  task automatic cpu_idle();
    cpu_mrq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  task automatic drive_idle();
    cpu_idle();
    scr_req = 1'b0;
  endtask

  task automatic wait_ack(input bit is_scr, input bit chk_bus, input logic [3:0] bus,
                          output int lat, output bit other);
    bit got;
    got = 1'b0; lat = 0; other = 1'b0;
    while (!got && lat < 16) begin
      @(negedge mck);
      lat++;
      if (is_scr ? cpu_ack : scr_ack) other = 1'b1;
      if (is_scr ? scr_ack : cpu_ack) got = 1'b1;
      else if (chk_bus && lat <= ACC_CYC) begin
        chk("bus", 32'(bus ^ {moe_n, mwe_n, ipce_n, irce_n}), 32'(0));
        if (!is_scr) chk("wait_n_low", 32'(cpu_wait_n), 32'(0));
      end
    end
    if (!got) lat = 99;
  endtask

  // kind: 0 CPU read, 1 CPU write, 2 screen fetch; starts and ends in IDLE.
  task automatic do_acc(input int kind, input logic [21:0] a, input logic [7:0] d);
    bit wr, scr, other;
    int lat;
    logic [7:0] e;
    wr  = (kind == 1);
    scr = (kind == 2);
    e   = wr ? last_rd : ref_mem[a[5:0]];
    exp_q.push_back(e);
    if (scr) scr_a = a; else drive_cpu(wr, a, d);
    if (scr) scr_req = 1'b1;
    wait_ack(scr, 1'b1, exp_bus(wr, a), lat, other);
    chk("latency", 32'(lat), 32'(ACC_CYC + 1));
    chk("other_ack", 32'(other), 32'(0));
    if (!scr) chk("wait_n_ack", 32'(cpu_wait_n), 32'(1));
    chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
    chk("turn_bus", 32'({moe_n, mwe_n, ipce_n, irce_n}), 32'(4'hF));
    drive_idle();
    if (wr && a[21:19] != 3'b000) ref_mem[a[5:0]] = d;
    if (!wr) last_rd = e;
    @(negedge mck);
    chk("idle_ack", 32'({cpu_ack, scr_ack}), 32'(0));
  endtask

  initial begin
    int lat;
    bit other;
    logic [2:0] regions[4];
    logic [21:0] a;

    regions[0] = 3'b000; regions[1] = 3'b001; regions[2] = 3'b010; regions[3] = 3'b111;
    for (int i = 0; i < 64; i++) seed_mem[i] = 8'($urandom);
    seed_mem[16] = 8'hA5;
    seed_mem[35] = 8'h3C;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_mem[i];

    // Reset held for two edges.
    repeat (2) @(negedge mck);
    chk("rst_bus", 32'({moe_n, mwe_n, ipce_n, irce_n}), 32'(4'hF));
    chk("rst_acks", 32'({cpu_ack, scr_ack, cpu_wait_n}), 32'(3'b001));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_ma", 32'(ma), 32'(0));
    chk("rst_mdo", 32'(mdo), 32'(0));
    mem_load = 1'b0;
    rin_n = 1'b1;
    @(negedge mck);
    chk("idle_bus", 32'({moe_n, mwe_n, ipce_n, irce_n}), 32'(4'hF));

    // Directed single accesses.
    do_acc(0, 22'h080010, 8'h00);
    chk("cpu_read_a5", 32'(last_rd), 32'(8'hA5));
    do_acc(2, 22'h000123, 8'h00);
    chk("scr_read_3c", 32'(last_rd), 32'(8'h3C));
    do_acc(1, 22'h000005, 8'h77);
    do_acc(0, 22'h000005, 8'h00);
    do_acc(1, 22'h080007, 8'h5A);
    do_acc(0, 22'h080007, 8'h00);
    do_acc(0, 22'h3F0002, 8'h00);

    // Simultaneous requests: CPU first, screen after turnaround and idle.
    drive_cpu(1'b0, 22'h080001, 8'h00);
    scr_a = 22'h000002; scr_req = 1'b1;
    wait_ack(1'b0, 1'b1, exp_bus(1'b0, 22'h080001), lat, other);
    chk("conf_cpu_lat", 32'(lat), 32'(ACC_CYC + 1));
    chk("conf_cpu_other", 32'(other), 32'(0));
    chk("conf_cpu_rdata", 32'(rdata), 32'(ref_mem[1]));
    cpu_idle();
    wait_ack(1'b1, 1'b0, 4'hF, lat, other);
    chk("conf_scr_lat", 32'(lat), 32'(ACC_CYC + 2));
    chk("conf_scr_rdata", 32'(rdata), 32'(ref_mem[2]));
    last_rd = ref_mem[2];
    drive_idle();
    @(negedge mck);

    // Sustained CPU traffic keeps a waiting screen locked out.
    scr_a = 22'h080003; scr_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_cpu(1'b0, 22'h080008 + 22'(k), 8'h00);
      wait_ack(1'b0, 1'b1, exp_bus(1'b0, 22'h080008), lat, other);
      chk("hold_cpu_lat", 32'(lat), 32'(ACC_CYC + 1));
      chk("hold_no_scr", 32'(other), 32'(0));
      chk("hold_rdata", 32'(rdata), 32'(ref_mem[8 + k]));
      cpu_idle();
      @(negedge mck);
    end
    wait_ack(1'b1, 1'b0, 4'hF, lat, other);
    chk("hold_scr_lat", 32'(lat), 32'(ACC_CYC + 1));
    chk("hold_scr_rdata", 32'(rdata), 32'(ref_mem[3]));
    last_rd = ref_mem[3];
    drive_idle();
    @(negedge mck);

    // Screen request is ignored while the display is off.
    lcdon = 1'b0; scr_a = 22'h080004; scr_req = 1'b1;
    repeat (6) begin
      @(negedge mck);
      chk("lcdoff_quiet", 32'({scr_ack, moe_n}), 32'(2'b01));
    end
    drive_idle();
    lcdon = 1'b1;
    @(negedge mck);

    // Display switched off mid-fetch: the fetch still completes.
    scr_a = 22'h080004; scr_req = 1'b1;
    @(negedge mck);
    lcdon = 1'b0;
    wait_ack(1'b1, 1'b0, 4'hF, lat, other);
    chk("lcdfall_lat", 32'(lat), 32'(ACC_CYC));
    chk("lcdfall_rdata", 32'(rdata), 32'(ref_mem[4]));
    last_rd = ref_mem[4];
    drive_idle();
    lcdon = 1'b1;
    @(negedge mck);

    // Reset in the middle of an access aborts it without an ack.
    drive_cpu(1'b0, 22'h080006, 8'h00);
    @(negedge mck);
    chk("abort_irce", 32'(irce_n), 32'(0));
    rin_n = 1'b0;
    drive_idle();
    @(negedge mck);
    chk("abort_bus", 32'({moe_n, mwe_n, ipce_n, irce_n}), 32'(4'hF));
    chk("abort_state", 32'({ma, rdata, cpu_ack}), 32'(0));
    rin_n = 1'b1;
    last_rd = '0;
    repeat (4) begin
      @(negedge mck);
      chk("abort_no_ack", 32'({cpu_ack, scr_ack}), 32'(0));
    end

    // Random accesses across ROM, RAM and unmapped regions.
    repeat (24) begin
      a = {regions[$urandom_range(0, 3)], 13'($urandom), 6'($urandom_range(0, 7))};
      do_acc(int'($urandom_range(0, 2)), a, 8'($urandom));
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the Z88 memory bus (ROM via ipce_n, internal RAM via irce_n) between the Z80 CPU and the screen fetch engine.
- Replaces the ad-hoc "fetch when mrq_n high" gating with an explicit request/grant scheduler.
- Drives ma, chip selects and strobes, and returns one registered read-data byte to whichever requester owns the completed access.
- Sits between the CPU bus interface, the screen fetcher and the memory pins.

Parameters:
- ACC_CYC, 2, memory access length in mck cycles (legal range 1..7).
- STARVE_MAX, 8, screen wait limit in mck cycles before a forced screen slot (used only with the optional feature).

Ports:
- mck  input  1  system clock; all logic on rising edge.
- rin_n  input  1  reset, synchronous, active-low.
- lcdon  input  1  screen enable; when 0, scr_req is ignored.
- cpu_mrq_n  input  1  CPU memory request, active-low.
- cpu_rd_n  input  1  CPU read strobe, active-low.
- cpu_wr_n  input  1  CPU write strobe, active-low.
- cpu_a  input  22  CPU physical address (after bank mapping).
- cpu_do  input  8  CPU write data.
- cpu_wait_n  output  1  low while a CPU request is pending or in progress.
- cpu_ack  output  1  one-cycle pulse; CPU access complete, rdata valid.
- scr_req  input  1  screen fetch request; level, held until scr_ack.
- scr_a  input  22  screen fetch address.
- scr_ack  output  1  one-cycle pulse; screen fetch complete, rdata valid.
- rdata  output  8  registered read data.
- cdi  input  8  memory read data bus.
- ma  output  22  memory address.
- mdo  output  8  memory write data.
- moe_n  output  1  memory output enable, active-low.
- mwe_n  output  1  memory write enable, active-low.
- ipce_n  output  1  ROM chip enable; low iff ma[21:19]==3'b000 during an access.
- irce_n  output  1  RAM chip enable; low iff ma[21:19]==3'b001 during an access.

Behaviour:
- Reset (rin_n==0 at a mck edge):
  - state=IDLE; ma=0, mdo=0, rdata=0.
  - moe_n=1, mwe_n=1, ipce_n=1, irce_n=1.
  - cpu_wait_n=1, cpu_ack=0, scr_ack=0; wait counters=0.
  - Reset mid-access aborts the access immediately; no ack is issued.
- States: IDLE, CPU_ACC, SCR_ACC, TURN.
- IDLE arbitration, evaluated every edge:
  - cpu_req = !cpu_mrq_n & (!cpu_rd_n | !cpu_wr_n).
  - scr_v = scr_req & lcdon.
  - If cpu_req: go to CPU_ACC; latch ma=cpu_a, mdo=cpu_do, write flag = !cpu_wr_n.
  - Else if scr_v: go to SCR_ACC; latch ma=scr_a; read only.
  - Fixed priority is CPU over screen. A started access is never preempted.
- Access states:
  - Last exactly ACC_CYC cycles (cycle counter 3 bits).
  - Read: moe_n=0 throughout.
  - Write: mwe_n=0 throughout, except mwe_n stays 1 when ma[21:19]==3'b000 (ROM write dropped silently; access still completes and acks).
  - Chip enables decoded from latched ma. Address outside 000/001 enables neither; the access still completes, and rdata captures cdi as-is.
  - On the final access cycle edge: rdata<=cdi (reads only; writes leave rdata unchanged); pulse the owner's ack next cycle; go to TURN.
- TURN:
  - One cycle with all strobes and enables deasserted (bus turnaround); then IDLE.
  - Request-to-ack latency from idle is ACC_CYC+1 cycles. Back-to-back throughput is one access per ACC_CYC+2 cycles.
- cpu_wait_n:
  - 0 whenever cpu_req is true and the cycle is not the cpu_ack cycle.
  - 1 in the cpu_ack cycle and when there is no request.
  - The CPU drops its request after the ack; a request still held in the following IDLE is treated as a new access.
- Simultaneous requests in IDLE: CPU wins; the screen keeps waiting.
- lcdon falling while SCR_ACC is in progress: the access completes and scr_ack is still issued.

Optional Feature:
- Macro: MEM_ARBITER_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments each cycle scr_v is high and not granted, saturating at STARVE_MAX.
  - At STARVE_MAX, the next IDLE grants the screen even if cpu_req is high.
  - The counter clears on grant.
- Undefined: pure fixed CPU priority; the counter logic is absent. The screen can starve indefinitely.

Decomposition:
- Shared package z88_mem_pkg:
  - state enum (IDLE/CPU_ACC/SCR_ACC/TURN).
  - constants ROM_SEL=3'b000 and RAM_SEL=3'b001.
  - address width constant MA_W=22.
- Sub-module mem_cs_decode (combinational chip-select decode from ma plus an access-active bit), reusable by other bus masters.

Test Plan:
- Reset: hold rin_n=0 for 2 cycles -> all outputs at reset values; release with no requests -> IDLE; moe_n, mwe_n, ipce_n, irce_n all 1.
- CPU read: cpu_a=22'h080010 (RAM), cdi=8'hA5, ACC_CYC=2 -> irce_n=0 and moe_n=0 for 2 cycles; cpu_ack at request+3 with rdata=8'hA5; cpu_wait_n low until the ack cycle.
- Screen fetch: scr_req with scr_a=22'h000123 (ROM), cdi=8'h3C -> ipce_n=0; scr_ack at +3 with rdata=8'h3C; TURN cycle follows.
- Conflict: cpu_req and scr_req asserted on the same edge -> CPU_ACC first, then TURN, then SCR_ACC. Without the macro, sustained CPU requests hold off scr_ack indefinitely.
- ROM write: cpu_wr_n=0, cpu_a=22'h000005 -> mwe_n stays 1, ipce_n=0; cpu_ack still pulses; rdata unchanged.
- Starve guard (macro on, STARVE_MAX=8): continuous CPU requests plus scr_req -> screen granted at the first IDLE after 8 waiting cycles; scr_ack issued; the CPU then resumes.
